// File: rtl/mcs4_pkg.sv
// Shared types and widths for the MCS-4 bus sequencer.
// Subcycles are numbered in bus order, A1=0 through X3=7.
package mcs4_pkg;
  localparam int MCS4_ADDR_W = 12;
  localparam int MCS4_DATA_W = 4;

  typedef enum logic [2:0] {
    CYC_A1 = 3'd0,
    CYC_A2 = 3'd1,
    CYC_A3 = 3'd2,
    CYC_M1 = 3'd3,
    CYC_M2 = 3'd4,
    CYC_X1 = 3'd5,
    CYC_X2 = 3'd6,
    CYC_X3 = 3'd7
  } mcs4_cycle_t;
endpackage

// File: rtl/mcs4_phase_det.sv
// Turns the sampled two-phase clock into a one-clk subcycle advance.
// A PHI2 fall only counts when a PHI1 pulse was seen since the last one.
module mcs4_phase_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic PHI1_i,
  input  logic PHI2_i,
  output logic adv_o
);
  import mcs4_pkg::*;

  logic phi2_q, phi2_d;
  logic phi1_seen_q, phi1_seen_d;
  logic adv_q, adv_d;

  always_comb begin
    phi2_d = PHI2_i;
    adv_d = phi2_q & ~PHI2_i & phi1_seen_q;
    // a PHI1 on the advancing edge re-arms for the next fall
    phi1_seen_d = PHI1_i | (phi1_seen_q & ~adv_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phi2_q <= 1'b0;
      phi1_seen_q <= 1'b0;
      adv_q <= 1'b0;
    end else begin
      phi2_q <= phi2_d;
      phi1_seen_q <= phi1_seen_d;
      adv_q <= adv_d;
    end
  end

  assign adv_o = adv_q;
endmodule

// File: rtl/mcs4_cycle_seq.sv
// MCS-4 instruction-cycle sequencer: subcycle counter, PC,
// address nibble drive and OPR/OPA capture, all outputs registered.
module mcs4_cycle_seq #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        PHI1_i,
  input  logic        PHI2_i,
  input  logic [3:0]  D_i,
  output logic [3:0]  D_o,
  output logic        D_oe_o,
  output logic        SYNC_o,
  output logic        CM_ROM_o,
  output logic [2:0]  cycle_o,
  input  logic        jmp_i,
  input  logic [11:0] jmp_addr_i,
  output logic [11:0] pc_o,
  output logic [7:0]  instr_o,
  output logic        instr_valid_o
);
  import mcs4_pkg::*;

  logic adv;

  mcs4_phase_det u_phase (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .PHI1_i (PHI1_i),
    .PHI2_i (PHI2_i),
    .adv_o  (adv)
  );

  mcs4_cycle_t cycle_q, cycle_d;
  logic started_q, started_d;
  logic [MCS4_ADDR_W-1:0] pc_q, pc_d;
  logic [MCS4_DATA_W-1:0] opr_q, opr_d;
  logic [7:0] instr_q, instr_d;
  logic valid_q, valid_d;
  logic [MCS4_DATA_W-1:0] d_q, d_d;
  logic oe_q, oe_d;
  logic sync_q, sync_d;
  logic cm_q, cm_d;

  always_comb begin
    cycle_d = cycle_q;
    started_d = started_q;
    pc_d = pc_q;
    opr_d = opr_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    if (adv) begin
      cycle_d = mcs4_cycle_t'(cycle_q + 3'd1);
      started_d = 1'b1;
      if (cycle_q == CYC_M1) opr_d = D_i;
      if (cycle_q == CYC_M2) begin
        instr_d = {opr_q, D_i};
        valid_d = 1'b1;
        pc_d = jmp_i ? jmp_addr_i : pc_q + 12'd1;
      end
    end
    // bus and strobes follow the subcycle being entered
    d_d = '0;
    oe_d = 1'b0;
    case (cycle_d)
      CYC_A1: begin d_d = pc_d[3:0];  oe_d = 1'b1; end
      CYC_A2: begin d_d = pc_d[7:4];  oe_d = 1'b1; end
      CYC_A3: begin d_d = pc_d[11:8]; oe_d = 1'b1; end
      default: begin d_d = '0; oe_d = 1'b0; end
    endcase
    sync_d = (cycle_d == CYC_X3) & started_d;
    cm_d = (cycle_d == CYC_A3);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_q <= CYC_X3;
      started_q <= 1'b0;
      pc_q <= RESET_PC;
      opr_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      d_q <= '0;
      oe_q <= 1'b0;
      sync_q <= 1'b0;
      cm_q <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      started_q <= started_d;
      pc_q <= pc_d;
      opr_q <= opr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      d_q <= d_d;
      oe_q <= oe_d;
      sync_q <= sync_d;
      cm_q <= cm_d;
    end
  end

  assign cycle_o = cycle_q;
  assign pc_o = pc_q;
  assign instr_o = instr_q;
  assign instr_valid_o = valid_q;
  assign D_o = d_q;
  assign D_oe_o = oe_q;
  assign SYNC_o = sync_q;
  assign CM_ROM_o = cm_q;
endmodule

// File: tb/tb_mcs4_cycle_seq.sv
// Directed + randomized bench for mcs4_cycle_seq against a
// subcycle-level bus model with a random ROM image.
module tb_mcs4_cycle_seq;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic PHI1_i = 1'b0;
  logic PHI2_i = 1'b0;
  logic [3:0] D_i = '0;
  logic jmp_i = 1'b0;
  logic [11:0] jmp_addr_i = '0;
  logic [3:0] D_o;
  logic D_oe_o, SYNC_o, CM_ROM_o, instr_valid_o;
  logic [2:0] cycle_o;
  logic [11:0] pc_o;
  logic [7:0] instr_o;

  mcs4_cycle_seq dut (
    .clk_i(clk), .rst_i(rst_i), .PHI1_i(PHI1_i), .PHI2_i(PHI2_i),
    .D_i(D_i), .D_o(D_o), .D_oe_o(D_oe_o), .SYNC_o(SYNC_o),
    .CM_ROM_o(CM_ROM_o), .cycle_o(cycle_o), .jmp_i(jmp_i),
    .jmp_addr_i(jmp_addr_i), .pc_o(pc_o), .instr_o(instr_o),
    .instr_valid_o(instr_valid_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int vcnt = 0;

  always @(negedge clk) if (instr_valid_o === 1'b1) vcnt++;

  // reference model: subcycle index, pc, last instruction
  logic [7:0] rom [4096];
  int sc;
  bit started;
  logic [11:0] mpc;
  logic [3:0] mopr;
  logic [7:0] minstr;
  int vexp = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sc = 7;
    started = 0;
    mpc = 12'h000;
    minstr = 8'h00;
  endtask

  task automatic check_all();
    logic [3:0] ed;
    bit eoe;
    eoe = (sc <= 2);
    ed = eoe ? 4'((mpc >> (4 * sc)) & 12'hF) : 4'h0;
    chk("cycle", 32'(cycle_o), 32'(sc));
    chk("d_oe", 32'(D_oe_o), 32'(eoe));
    chk("d_o", 32'(D_o), 32'(ed));
    chk("sync", 32'(SYNC_o), 32'(sc == 7 && started));
    chk("cm_rom", 32'(CM_ROM_o), 32'(sc == 2));
    chk("pc", 32'(pc_o), 32'(mpc));
    chk("instr", 32'(instr_o), 32'(minstr));
    chk("valid_cnt", 32'(vcnt), 32'(vexp));
  endtask

  task automatic pair();
    PHI1_i = 1; tick(2); PHI1_i = 0; tick(1);
    PHI2_i = 1; tick(2); PHI2_i = 0; tick(3);
  endtask

  // one subcycle: drive ROM/jump inputs, pulse the phases, check
  task automatic run_step(input bit fj, input logic [11:0] fa);
    bit doj;
    logic [11:0] ja;
    doj = 0;
    ja = 12'($urandom);
    if (sc == 3) D_i = rom[mpc][7:4];
    else if (sc == 4) D_i = rom[mpc][3:0];
    else D_i = 4'($urandom);
    if (sc == 4) begin
      doj = fj || ($urandom_range(0, 3) == 0);
      if (fj) ja = fa;
      jmp_i = doj;
    end else begin
      jmp_i = 1'($urandom);
    end
    jmp_addr_i = ja;
    pair();
    jmp_i = 0;
    if (sc == 3) mopr = rom[mpc][7:4];
    if (sc == 4) begin
      minstr = {mopr, rom[mpc][3:0]};
      vexp++;
      mpc = doj ? ja : mpc + 12'd1;
    end
    sc = (sc + 1) % 8;
    started = 1;
    check_all();
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 8 && sc != target; k++) run_step(0, 12'h0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    rom[0] = 8'hD5;
    model_reset();
    tick(2);
    rst_i = 0;
    check_all();

    // nominal fetch from address 0
    for (int i = 0; i < 8; i++) run_step(0, 12'h0);
    chk("nominal_instr", 32'(instr_o), 32'h0D5);

    // wrap: jump to FFE then run three more cycles
    run_to(4);
    run_step(1, 12'hFFE);
    for (int i = 0; i < 24; i++) run_step(0, 12'h0);

    // directed jump target
    run_to(4);
    run_step(1, 12'h2A7);
    chk("jump_pc", 32'(pc_o), 32'h2A7);

    // glitch: PHI2 pulse with no PHI1
    PHI2_i = 1; tick(2); PHI2_i = 0; tick(3);
    check_all();
    run_step(0, 12'h0);

    // randomized cycles
    for (int i = 0; i < 200; i++) run_step(0, 12'h0);

    // reset during M2
    run_to(4);
    PHI1_i = 1; tick(2); PHI1_i = 0; tick(1);
    PHI2_i = 1;
    rst_i = 1; tick(1); rst_i = 0;
    model_reset();
    check_all();
    tick(1); PHI2_i = 0; tick(3);
    check_all();
    run_step(0, 12'h0);
    for (int i = 0; i < 16; i++) run_step(0, 12'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
